// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants for the RV32IC core.
package riscv_pkg;

   localparam logic [1:0]  CINSTR_MASK      = 2'b11;
   localparam int unsigned FETCH_WORD_BYTES = 4;

   typedef struct packed {
      logic        err;
      logic [31:0] data;
   } fetch_entry_t;

   typedef enum logic {
      ALIGN_ALIGNED = 1'b0,
      ALIGN_RESIDUE = 1'b1
   } align_state_e;

   // A halfword starts a 16-bit instruction unless its two low bits are 11.
   function automatic logic is_compressed(input logic [15:0] half);
      return half[1:0] != CINSTR_MASK;
   endfunction

endpackage

// File: rtl/fetch_aligner.sv
// Halfword aligner: turns the word stream into one 16/32-bit instruction per handshake.
//
// state         | meaning
// ALIGN_ALIGNED | no residue; next instruction starts at the FIFO head word
// ALIGN_RESIDUE | upper half of the previous word held in residue, out_pc[1]=1
module fetch_aligner
   import riscv_pkg::*;
(
   input  logic         clk,
   input  logic         reset_n,
   input  logic [31:0]  boot_pc,
   input  logic         branch_valid,
   input  logic [31:0]  branch_addr,
   input  logic         head_valid,
   input  fetch_entry_t head,
   input  logic         out_ready,
   output logic         pop,
   output logic         out_valid,
   output logic [31:0]  out_instr,
   output logic [31:0]  out_pc,
   output logic         out_compress,
   output logic         out_err
);

   align_state_e state_q, state_d;
   logic [15:0]  residue_q, residue_d;
   logic         residue_err_q, residue_err_d;
   logic         skip_half_q, skip_half_d;
   logic [31:0]  pc_q;
   logic         fire;

   assign fire   = out_valid & out_ready;
   assign out_pc = pc_q;

   // Next-state, output and pop decode; a redirect suppresses everything.
   always_comb begin
      state_d       = state_q;
      residue_d     = residue_q;
      residue_err_d = residue_err_q;
      skip_half_d   = skip_half_q;
      pop           = 1'b0;
      out_valid     = 1'b0;
      out_instr     = '0;
      out_compress  = 1'b0;
      out_err       = 1'b0;
      if (!branch_valid) begin
         case (state_q)
            ALIGN_ALIGNED: begin
               if (head_valid) begin
                  if (skip_half_q) begin
                     // Redirect into the upper half: drop the lower half silently.
                     pop           = 1'b1;
                     residue_d     = head.data[31:16];
                     residue_err_d = head.err;
                     skip_half_d   = 1'b0;
                     state_d       = ALIGN_RESIDUE;
                  end else if (is_compressed(head.data[15:0])) begin
                     out_valid    = 1'b1;
                     out_instr    = {16'h0000, head.data[15:0]};
                     out_compress = 1'b1;
                     out_err      = head.err;
                     if (out_ready) begin
                        pop           = 1'b1;
                        residue_d     = head.data[31:16];
                        residue_err_d = head.err;
                        state_d       = ALIGN_RESIDUE;
                     end
                  end else begin
                     out_valid = 1'b1;
                     out_instr = head.data;
                     out_err   = head.err;
                     pop       = out_ready;
                  end
               end
            end
            ALIGN_RESIDUE: begin
               if (is_compressed(residue_q)) begin
                  out_valid    = 1'b1;
                  out_instr    = {16'h0000, residue_q};
                  out_compress = 1'b1;
                  out_err      = residue_err_q;
                  if (out_ready) state_d = ALIGN_ALIGNED;
               end else if (head_valid) begin
                  out_valid = 1'b1;
                  out_instr = {head.data[15:0], residue_q};
                  out_err   = residue_err_q | head.err;
                  if (out_ready) begin
                     pop           = 1'b1;
                     residue_d     = head.data[31:16];
                     residue_err_d = head.err;
                  end
               end
            end
            default: state_d = ALIGN_ALIGNED;
         endcase
      end
   end

   // State, residue and PC registers; redirect reloads PC and half-skip.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ALIGN_ALIGNED;
         residue_q     <= '0;
         residue_err_q <= 1'b0;
         skip_half_q   <= boot_pc[1];
         pc_q          <= boot_pc;
      end else if (branch_valid) begin
         state_q       <= ALIGN_ALIGNED;
         residue_q     <= '0;
         residue_err_q <= 1'b0;
         skip_half_q   <= branch_addr[1];
         pc_q          <= branch_addr;
      end else begin
         state_q       <= state_d;
         residue_q     <= residue_d;
         residue_err_q <= residue_err_d;
         skip_half_q   <= skip_half_d;
         if (fire) pc_q <= pc_q + (out_compress ? 32'd2 : 32'd4);
      end
   end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; push on a full FIFO is accepted when popping in the same cycle.
module sync_fifo #(
   parameter int DATA_WIDTH = 33,
   parameter int DEPTH      = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     clear,
   input  logic                     push,
   input  logic [DATA_WIDTH-1:0]    wdata,
   input  logic                     pop,
   output logic [DATA_WIDTH-1:0]    rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW:0]           cnt;
   logic                  full;
   logic                  wr_en;
   logic                  rd_en;

   assign empty = (cnt == '0);
   assign full  = (cnt == (AW+1)'(DEPTH));
   assign wr_en = push & (~full | pop);
   assign rd_en = pop & ~empty;
   assign rdata = mem[rd_ptr];
   assign count = cnt;

   // Pointer and occupancy tracking; clear empties the FIFO in one cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         cnt <= cnt + (AW+1)'(wr_en) - (AW+1)'(rd_en);
      end
   end

   // Storage array, written without reset.
   always_ff @(posedge clk) begin
      if (wr_en && !clear) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch unit: credit-based bus requests, word FIFO, stale-response discard, aligner.
module fetch_prefetch_buffer
   import riscv_pkg::*;
#(
   parameter int DEPTH                = 4,
   parameter int MAX_OUTSTANDING      = 2,
   parameter int RESET_PC_ALIGN_CHECK = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [31:0]  boot_addr,
   input  logic         fetch_enable,
   input  logic         branch_valid,
   input  logic [31:0]  branch_addr,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [31:0]  out_instr,
   output logic [31:0]  out_pc,
   output logic         out_compress,
   output logic         out_err,
   output logic         busy,
   output logic         instr_req,
   output logic [31:0]  instr_addr,
   input  logic         instr_gnt,
   input  logic [31:0]  instr_rdata,
   input  logic         instr_err,
   input  logic         instr_valid
);

   localparam int          CW      = $clog2(DEPTH) + 1;
   localparam int          OW      = $clog2(MAX_OUTSTANDING + 1);
   // Discards can pile up across back-to-back redirects, so give headroom.
   localparam int          DW      = 8;
   localparam logic [31:0] DEPTH_U = 32'(DEPTH);

   logic [31:0]   boot_pc;
   logic [31:0]   fetch_addr_q;
   logic [OW-1:0] outstanding_q;
   logic [DW-1:0] discard_q;
   logic          run_q;
   logic [CW-1:0] fifo_count;
   logic          fifo_empty;
   logic          fifo_pop;
   fetch_entry_t  push_entry;
   fetch_entry_t  head;
   logic [OW-1:0] credit_out;
   logic [CW-1:0] credit_fifo;
   logic [31:0]   credit_sum;
   logic          grant;
   logic          rsp_drop;
   logic          rsp_keep;

   assign boot_pc = (RESET_PC_ALIGN_CHECK != 0) ? {boot_addr[31:1], 1'b0} : boot_addr;

   // On a redirect the FIFO and the stale credits are gone, so check against empty.
   assign credit_out  = branch_valid ? '0 : outstanding_q;
   assign credit_fifo = branch_valid ? '0 : fifo_count;
   assign credit_sum  = 32'(credit_fifo) + 32'(credit_out);

   assign instr_req  = run_q & fetch_enable & (credit_out < OW'(MAX_OUTSTANDING)) & (credit_sum < DEPTH_U);
   assign instr_addr = branch_valid ? {branch_addr[31:2], 2'b00} : {fetch_addr_q[31:2], 2'b00};
   assign grant      = instr_req & instr_gnt;

   assign rsp_drop   = instr_valid & (discard_q != '0);
   assign rsp_keep   = instr_valid & ~rsp_drop;
   assign push_entry = '{err: instr_err, data: instr_rdata};
   assign busy       = (outstanding_q != '0) | ~fifo_empty;

   // Fetch address and in-flight accounting; redirect turns live credits into discards.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run_q         <= 1'b0;
         fetch_addr_q  <= boot_pc;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         run_q        <= 1'b1;
         fetch_addr_q <= grant ? instr_addr + 32'(FETCH_WORD_BYTES) : instr_addr;
         if (branch_valid) begin
            discard_q     <= discard_q + DW'(outstanding_q) - DW'(instr_valid);
            outstanding_q <= OW'(grant);
         end else begin
            discard_q     <= discard_q - DW'(rsp_drop);
            outstanding_q <= outstanding_q + OW'(grant) - OW'(rsp_keep);
         end
      end
   end

   instr_valid_in_flight: assert property (@(posedge clk) disable iff (!reset_n)
      instr_valid |-> (outstanding_q != '0 || discard_q != '0));

   sync_fifo #(
      .DATA_WIDTH (33),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (branch_valid),
      .push    (rsp_keep & ~branch_valid),
      .wdata   (push_entry),
      .pop     (fifo_pop),
      .rdata   (head),
      .count   (fifo_count),
      .empty   (fifo_empty)
   );

   fetch_aligner u_aligner (
      .clk          (clk),
      .reset_n      (reset_n),
      .boot_pc      (boot_pc),
      .branch_valid (branch_valid),
      .branch_addr  (branch_addr),
      .head_valid   (~fifo_empty),
      .head         (head),
      .out_ready    (out_ready),
      .pop          (fifo_pop),
      .out_valid    (out_valid),
      .out_instr    (out_instr),
      .out_pc       (out_pc),
      .out_compress (out_compress),
      .out_err      (out_err)
   );

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Scoreboard bench for fetch_prefetch_buffer with a latency-programmable memory model.
module tb_fetch_prefetch_buffer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] boot_addr;
   logic        fetch_enable;
   logic        branch_valid;
   logic [31:0] branch_addr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_compress;
   logic        out_err;
   logic        busy;
   logic        instr_req;
   logic [31:0] instr_addr;
   logic        instr_gnt;
   logic [31:0] instr_rdata;
   logic        instr_err;
   logic        instr_valid;

   always #5 clk = ~clk;

   fetch_prefetch_buffer #(
      .DEPTH                (4),
      .MAX_OUTSTANDING      (2),
      .RESET_PC_ALIGN_CHECK (1)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .boot_addr    (boot_addr),
      .fetch_enable (fetch_enable),
      .branch_valid (branch_valid),
      .branch_addr  (branch_addr),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_instr    (out_instr),
      .out_pc       (out_pc),
      .out_compress (out_compress),
      .out_err      (out_err),
      .busy         (busy),
      .instr_req    (instr_req),
      .instr_addr   (instr_addr),
      .instr_gnt    (instr_gnt),
      .instr_rdata  (instr_rdata),
      .instr_err    (instr_err),
      .instr_valid  (instr_valid)
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        comp;
      logic        err;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } rsp_t;

   exp_t        sb[$];
   rsp_t        inflight[$];
   logic [31:0] mem  [logic [31:0]];
   logic        errm [logic [31:0]];
   int          checks = 0;
   int          passed = 0;
   int          cyc = 0;
   int          lat = 1;
   logic        presenting = 1'b0;
   logic [31:0] exp_addr = 32'h0;
   exp_t        mon_e;
   rsp_t        drv_r;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, req);
   endtask

   task automatic expect_out(input logic [31:0] instr, input logic [31:0] pc, input logic comp, input logic err);
      exp_t e;
      e.instr = instr; e.pc = pc; e.comp = comp; e.err = err;
      sb.push_back(e);
   endtask

   // Monitor: every accepted instruction is compared against the scoreboard head.
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected_out: got %h@%h, expected no output", out_instr, out_pc);
         end else begin
            mon_e = sb.pop_front();
            check("out_instr", {6'b0, out_compress, out_err, out_instr, out_pc},
                  {6'b0, mon_e.comp, mon_e.err, mon_e.instr, mon_e.pc});
         end
      end
   end

   // Request sampler: checks the address sequence and queues the response.
   always @(negedge clk) begin
      if (!reset_n) begin
         exp_addr = {boot_addr[31:2], 2'b00};
      end else begin
         if (branch_valid) exp_addr = {branch_addr[31:2], 2'b00};
         if (instr_req && instr_gnt) begin
            check("req_addr", 72'(instr_addr), 72'(exp_addr));
            drv_r.addr = instr_addr;
            drv_r.due  = cyc + lat;
            inflight.push_back(drv_r);
            exp_addr = exp_addr + 32'd4;
         end
      end
   end

   // Response driver: one in-order response per cycle once its latency has elapsed.
   always @(posedge clk) begin
      cyc++;
      #1;
      if (!reset_n) begin
         inflight.delete();
         presenting  = 1'b0;
         instr_valid = 1'b0;
         instr_rdata = '0;
         instr_err   = 1'b0;
      end else begin
         if (presenting && inflight.size() > 0) inflight.delete(0);
         presenting  = 1'b0;
         instr_valid = 1'b0;
         if (inflight.size() > 0 && inflight[0].due <= cyc) begin
            presenting  = 1'b1;
            instr_valid = 1'b1;
            instr_rdata = mem.exists(inflight[0].addr) ? mem[inflight[0].addr] : 32'h00000013;
            instr_err   = errm.exists(inflight[0].addr) ? errm[inflight[0].addr] : 1'b0;
         end
      end
   end

   task automatic do_reset(input logic [31:0] ba);
      @(posedge clk); #1;
      reset_n      = 1'b0;
      boot_addr    = ba;
      branch_valid = 1'b0;
      out_ready    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_state", {3'b0, out_valid, instr_req, busy, out_err, out_compress, out_instr, out_pc},
            {3'b0, 5'b00000, 32'h0, ba});
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      out_ready = 1'b0;
      checks++;
      if (sb.size() == 0) passed++;
      else begin
         $display("FAIL %s_drain: %0d outputs outstanding, expected 0", name, sb.size());
         sb.delete();
      end
   endtask

   initial begin
      int n;
      reset_n = 1'b0; boot_addr = 32'h100; fetch_enable = 1'b1; branch_valid = 1'b0;
      branch_addr = '0; out_ready = 1'b0; instr_gnt = 1'b1;
      instr_valid = 1'b0; instr_rdata = '0; instr_err = 1'b0;

      // Straight-line 32-bit stream.
      mem.delete(); errm.delete(); lat = 1;
      for (int i = 0; i < 4; i++) mem[32'h100 + 32'(4 * i)] = 32'h00000013;
      do_reset(32'h100);
      for (int i = 0; i < 4; i++) expect_out(32'h00000013, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
      drain("nop_stream");

      // Two compressed then one full instruction.
      mem.delete(); errm.delete(); lat = 1;
      mem[32'h100] = 32'h45014501;
      mem[32'h104] = 32'h00A00093;
      do_reset(32'h100);
      expect_out(32'h00004501, 32'h100, 1'b1, 1'b0);
      expect_out(32'h00004501, 32'h102, 1'b1, 1'b0);
      expect_out(32'h00A00093, 32'h104, 1'b0, 1'b0);
      drain("mixed");

      // 32-bit instruction straddling a word boundary.
      mem.delete(); errm.delete(); lat = 1;
      mem[32'h100] = 32'h00934501;
      mem[32'h104] = 32'h12340000;
      do_reset(32'h100);
      expect_out(32'h00004501, 32'h100, 1'b1, 1'b0);
      expect_out(32'h00000093, 32'h102, 1'b0, 1'b0);
      expect_out(32'h00001234, 32'h106, 1'b1, 1'b0);
      drain("unaligned");

      // Redirect to 0x202 with two responses still in flight.
      mem.delete(); errm.delete(); lat = 3;
      mem[32'h100] = 32'hDEADBEEF;
      mem[32'h104] = 32'hDEADBEEF;
      mem[32'h200] = 32'h45010000;
      mem[32'h204] = 32'h00A00093;
      do_reset(32'h100);
      n = 0;
      while (!instr_req && n < 20) begin @(negedge clk); n++; end
      while (instr_req && n < 40) begin @(negedge clk); n++; end
      check("credit_block_wait", 72'(n < 40), 72'(1));
      expect_out(32'h00004501, 32'h202, 1'b1, 1'b0);
      expect_out(32'h00A00093, 32'h204, 1'b0, 1'b0);
      @(posedge clk); #1;
      branch_valid = 1'b1;
      branch_addr  = 32'h202;
      @(posedge clk); #1;
      branch_valid = 1'b0;
      drain("branch_discard");

      // Decode stall: requests stop at FIFO+outstanding=DEPTH, nothing lost afterwards.
      mem.delete(); errm.delete(); lat = 1;
      for (int i = 0; i < 8; i++) mem[32'h100 + 32'(4 * i)] = 32'h00000013 + 32'(i) * 32'h00100000;
      do_reset(32'h100);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("stall_req_busy", {70'b0, instr_req, busy}, {70'b0, 1'b0, 1'b1});
      for (int i = 0; i < 8; i++)
         expect_out(32'h00000013 + 32'(i) * 32'h00100000, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
      drain("stall_release");

      // Bus error on the middle word only.
      mem.delete(); errm.delete(); lat = 1;
      for (int i = 0; i < 3; i++) mem[32'h100 + 32'(4 * i)] = 32'h00000013;
      errm[32'h104] = 1'b1;
      do_reset(32'h100);
      expect_out(32'h00000013, 32'h100, 1'b0, 1'b0);
      expect_out(32'h00000013, 32'h104, 1'b0, 1'b1);
      expect_out(32'h00000013, 32'h108, 1'b0, 1'b0);
      drain("bus_error");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, checks);
      $fatal(1, "watchdog");
   end

endmodule
